pipeline_host_sequencer: RTL
============================

// Module: pipeline_host_sequencer
// PURPOSE
//  Host-side initiator for the 4-thread pipeline core. It replaces bench-driven stimulus.
//  It streams program words into instruction memory and packet words into the core FIFO (mode 00).
//  It then runs the threads round-robin (mode 10) for a programmed cycle count.
//  Finally it drains the core FIFO (mode 01) onto a valid/ready output stream.
//  Sits between the host/NetFPGA register+DMA logic and the pipeline core top.
// PARAMETERS
//  RD_LAT     1   cycles from mode_code=01 issue to valid core pkt_out
//  SKID_DEPTH 2   output buffer entries; must be >= RD_LAT+1
// PORTS
//  clk            in   1   single clock, all logic rising-edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   pulse: begin LOAD->RUN->DRAIN sequence (ignored unless IDLE)
//  run_cycles     in   16  RUN length in clocks, sampled on start
//  prog_valid     in   1   program write request
//  prog_addr      in   9   {thread[1:0],pc[6:0]}
//  prog_data      in   32  instruction word
//  prog_ready     out  1   write accepted this cycle
//  pkt_in_valid   in   1   / pkt_in_data in 64 / pkt_in_last in 1: inbound packet stream
//  pkt_in_ready   out  1   inbound beat accepted
//  pkt_out_valid  out  1   / pkt_out_data out 64 / pkt_out_last out 1: drained stream
//  pkt_out_ready  in   1   downstream accept
//  core_pkt_out   in   64  core FIFO read data
//  core_depth     in   8   core FIFO occupancy
//  core_afull     in   1   core FIFO_almost_FULL
//  core_rst       out  1   core rst
//  core_rst_fifo  out  1   core rst_FIFO
//  mode_code      out  2   00 fifo-in, 10 process, 01 fifo-out, 11 hold
//  thread_IF      out  2   fetch thread select
//  core_pkt_in    out  64  data into core FIFO
//  Instr_IN       out  32  / Instr_IN_addr out 9 / Instr_IN_en out 1: imem write port
//  busy           out  1   state != IDLE
//  done           out  1   one-cycle pulse on DRAIN completion
// BEHAVIOUR
//  Reset values: mode_code=11, core_rst=1, core_rst_fifo=1, thread_IF=0, Instr_IN_en=0.
//  Also at reset: prog_ready=0, pkt_in_ready=0, pkt_out_valid=0, busy=0, done=0, skid empty.
//  Reset mid-sequence: state IDLE on next cycle; in-flight and buffered drain data discarded.
//  FSM: IDLE -> FRST(1 clk, core_rst_fifo=1) -> LOAD -> RUN -> DRAIN -> IDLE.
//  IDLE: core_rst=1, core_rst_fifo=0 after first post-reset cycle, mode 11.
//  IDLE and LOAD accept program writes: prog_ready=1.
//  Program write path: Instr_IN/Instr_IN_addr/Instr_IN_en registered, 1-cycle latency.
//  LOAD: pkt_in_ready = !core_afull. Each accepted beat drives mode 00 with core_pkt_in=data.
//  LOAD idle cycles drive mode 11.
//  Accepted pkt_in_last -> RUN; if run_cycles==0, go straight to DRAIN.
//  RUN: core_rst=0, mode 10, thread_IF=0,1,2,3,0... starting 0 on first RUN clk.
//  RUN lasts exactly run_cycles clks; prog_ready=0.
//  DRAIN: core_rst=0. core_depth latched on entry as rd_left.
//  A read issues (mode 01) iff rd_left!=0 and skid free slots > reads in flight; else mode 11.
//  Reads land in the skid RD_LAT clks after issue.
//  pkt_out_last marks the final latched word.
//  DRAIN exits when rd_left==0, nothing in flight, and skid empty; done pulses that cycle.
//  If latched depth==0, DRAIN lasts 1 clk with no output beats.
//  Simultaneous skid push+pop at full is allowed; no data loss or duplication under any ready pattern.
//  start while busy is ignored.
// STRUCTURE
//  Shared package: MODE_FIFO_IN=2'b00, MODE_PROC=2'b10, MODE_FIFO_OUT=2'b01, MODE_HOLD=2'b11.
//  Also in the package: state enum, IMEM_ADDR_W=9, PKT_W=64.
//  Sub-module: pipeline_host_skid (SKID_DEPTH x 65b sync FIFO, data+last, push/pop same cycle).
// TESTING
//  Program write: prog 0x000<=0C010000, 0x080<=0C010001 -> Instr_IN_en 1 clk later, exact addr/data.
//  Load: 3 beats 460000481C464000, 04062A6D0A000D03, 0A000E0300000000(last).
//  Expected: 3 mode-00 cycles in order, then RUN.
//  Backpressure: core_afull=1 for 4 clks in LOAD -> pkt_in_ready=0, mode 11, no beat lost.
//  Run: run_cycles=64 -> exactly 64 mode-10 clks, thread_IF sequence 0,1,2,3 repeating, core_rst=0.
//  Drain: core_depth=3, pkt_out_ready toggling 1/0 -> 3 beats in FIFO order, last on 3rd, done pulse.
//  Reset: rst asserted mid-DRAIN -> next clk mode 11, pkt_out_valid=0, busy=0.
//  Reset follow-up: fresh start works normally.

Source files
------------

// File: rtl/pipeline_host_sequencer_pkg.sv
// pipeline_host_sequencer_pkg: shared mode codes, widths and sequencer states
package pipeline_host_sequencer_pkg;
  localparam logic [1:0] MODE_FIFO_IN = 2'b00;
  localparam logic [1:0] MODE_PROC = 2'b10;
  localparam logic [1:0] MODE_FIFO_OUT = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b11;
  localparam int IMEM_ADDR_W = 9;
  localparam int PKT_W = 64;
  typedef enum logic [2:0] {S_IDLE, S_FRST, S_LOAD, S_RUN, S_DRAIN} state_e;
endpackage

// File: rtl/pipeline_host_skid.sv
// pipeline_host_skid: small sync FIFO buffering drained words, push and pop allowed in one cycle
module pipeline_host_skid #(
  parameter int DEPTH = 2,
  parameter int W = 65,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/pipeline_host_sequencer.sv
// pipeline_host_sequencer: loads imem and core FIFO, runs threads round-robin, drains FIFO to a stream
module pipeline_host_sequencer
  import pipeline_host_sequencer_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            run_cycles,
  input  logic                   prog_valid,
  input  logic [IMEM_ADDR_W-1:0] prog_addr,
  input  logic [31:0]            prog_data,
  output logic                   prog_ready,
  input  logic                   pkt_in_valid,
  input  logic [PKT_W-1:0]       pkt_in_data,
  input  logic                   pkt_in_last,
  output logic                   pkt_in_ready,
  output logic                   pkt_out_valid,
  output logic [PKT_W-1:0]       pkt_out_data,
  output logic                   pkt_out_last,
  input  logic                   pkt_out_ready,
  input  logic [PKT_W-1:0]       core_pkt_out,
  input  logic [7:0]             core_depth,
  input  logic                   core_afull,
  output logic                   core_rst,
  output logic                   core_rst_fifo,
  output logic [1:0]             mode_code,
  output logic [1:0]             thread_IF,
  output logic [PKT_W-1:0]       core_pkt_in,
  output logic [31:0]            Instr_IN,
  output logic [IMEM_ADDR_W-1:0] Instr_IN_addr,
  output logic                   Instr_IN_en,
  output logic                   busy,
  output logic                   done
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  state_e state, state_n;
  logic [15:0] run_cnt;
  logic [1:0] thr;
  logic [7:0] rd_left;
  logic [RD_LAT-1:0] vpipe, lpipe;
  logic post_rst, accept, issue, fin, sk_empty;
  logic [CW-1:0] sk_cnt;
  logic [PKT_W:0] sk_dout;
  int infl;
  always_comb begin
    infl = 0;
    for (int i = 0; i < RD_LAT; i++) infl += int'(vpipe[i]);
    accept = state == S_LOAD && pkt_in_valid && !core_afull;
    issue = state == S_DRAIN && rd_left != 8'd0 && (SKID_DEPTH - int'(sk_cnt)) > infl;
    fin = state == S_DRAIN && rd_left == 8'd0 && infl == 0 && sk_empty;
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_FRST;
      S_FRST: state_n = S_LOAD;
      S_LOAD: if (accept && pkt_in_last) state_n = run_cnt == 16'd0 ? S_DRAIN : S_RUN;
      S_RUN: if (run_cnt == 16'd1) state_n = S_DRAIN;
      S_DRAIN: if (fin) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      post_rst <= 1'b1;
      run_cnt <= '0;
      thr <= '0;
      rd_left <= '0;
      vpipe <= '0;
      lpipe <= '0;
      Instr_IN_en <= 1'b0;
      Instr_IN <= '0;
      Instr_IN_addr <= '0;
    end else begin
      state <= state_n;
      post_rst <= 1'b0;
      if (state == S_IDLE && start) run_cnt <= run_cycles;
      else if (state == S_RUN) run_cnt <= run_cnt - 16'd1;
      thr <= state == S_RUN ? thr + 2'd1 : 2'd0;
      rd_left <= state != S_DRAIN && state_n == S_DRAIN ? core_depth : rd_left - 8'(issue);
      vpipe <= (vpipe << 1) | RD_LAT'(issue);
      lpipe <= (lpipe << 1) | RD_LAT'(issue && rd_left == 8'd1);
      Instr_IN_en <= prog_valid && prog_ready;
      if (prog_valid && prog_ready) begin
        Instr_IN <= prog_data;
        Instr_IN_addr <= prog_addr;
      end
    end
  pipeline_host_skid #(.DEPTH(SKID_DEPTH), .W(PKT_W + 1)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(vpipe[RD_LAT-1]),
    .pop(pkt_out_valid && pkt_out_ready),
    .din({lpipe[RD_LAT-1], core_pkt_out}),
    .dout(sk_dout),
    .empty(sk_empty),
    .count(sk_cnt)
  );
  assign prog_ready = !rst && (state == S_IDLE || state == S_LOAD);
  assign pkt_in_ready = !rst && state == S_LOAD && !core_afull;
  assign mode_code = rst ? MODE_HOLD : accept ? MODE_FIFO_IN : state == S_RUN ? MODE_PROC : issue ? MODE_FIFO_OUT : MODE_HOLD;
  assign core_rst = rst || !(state == S_RUN || state == S_DRAIN);
  assign core_rst_fifo = rst || post_rst || state == S_FRST;
  assign thread_IF = !rst && state == S_RUN ? thr : 2'd0;
  assign core_pkt_in = pkt_in_data;
  assign busy = !rst && state != S_IDLE;
  assign done = !rst && fin;
  assign pkt_out_valid = !rst && !sk_empty;
  assign pkt_out_data = sk_dout[PKT_W-1:0];
  assign pkt_out_last = sk_dout[PKT_W];
endmodule
